rd_pipelined_subtractor: RTL
============================

// Module: rd_pipelined_subtractor
// PURPOSE
//   Pipelined WIDTH-bit integer subtractor, D = A - B - bin. Borrows are resolved by
//   recursive doubling: kill/propagate/generate (KPG) prefix over A + ~B + ~bin.
//   Complements the recursive-doubling adder.
//   Feeds the same integer datapath and test benches. Accepts one operand pair per cycle.
//   Results carry a valid tag; the whole pipe stalls on en=0.
// PARAMETERS
//   WIDTH   32   operand width; power of two, 4..64
//   LOG_W   5    log2(WIDTH); number of doubling stages
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous, active-high reset
//   en        in   1      pipeline advance; 0 = every stage holds
//   in_valid  in   1      A/B/bin are a valid operation this cycle
//   A         in   WIDTH  minuend, unsigned or two's complement
//   B         in   WIDTH  subtrahend
//   bin       in   1      borrow-in, used for chaining wider subtracts
//   D         out  WIDTH  difference, mod 2^WIDTH
//   bout      out  1      borrow-out: 1 iff A < B + bin (unsigned)
//   ovf       out  1      signed overflow: A[W-1] != B[W-1] && D[W-1] != A[W-1]
//   out_valid out  1      D/bout/ovf belong to a valid operation
// BEHAVIOUR
//   - Reset: when rst=1 at a clk edge, all stage registers clear.
//     D=0, bout=0, ovf=0, out_valid=0 the next cycle. rst overrides en.
//   - Reset mid-operation: in-flight results are discarded; none emerge after reset.
//   - Stage 1 (input reg): latch A, B, in_valid.
//     Per bit: x = A[i], y = ~B[i].
//     KPG: K if x=y=0, G if x=y=1, else P. Bit -1 holds G if bin=0, K if bin=1.
//   - Stages 2..LOG_W+1 (doubling, distance d = 1,2,4..WIDTH/2):
//     new[i] = cur[i] o cur[i-d] for i-d >= -1; other positions pass through.
//     o: K o z = K, G o z = G, P o z = z.
//   - Final stage: carry c[i] = (resolved[i-1] == G).
//     D[i] = x ^ y ^ c[i]; cout = (resolved[W-1] == G); bout = ~cout.
//   - Every stage carries A[W-1], B[W-1] and the valid bit forward, so ovf can be formed at the output.
//   - Latency: exactly LOG_W+2 enabled edges from input sample to output (7 for WIDTH=32).
//     Throughput is 1/cycle with en=1.
//   - en=0: no register changes, including valid bits. Outputs hold their last value.
//     Inputs presented while en=0 are ignored.
//   - in_valid=0: the slot propagates as a bubble. Data fields are don't-care; out_valid=0 for that slot.
//   - Outputs are registered; no combinational input-to-output path.
//   - Boundaries:
//     - A=B, bin=0 -> D=0, bout=0.
//     - A=0, B=0, bin=1 -> D=all ones, bout=1.
//     - Borrow crossing all WIDTH bits resolves correctly within the fixed latency.
// TESTING
//   1. Reset, then A=5, B=3, bin=0, in_valid=1 for one cycle
//      -> after 7 cycles: D=2, bout=0, ovf=0, out_valid=1 for exactly 1 cycle.
//   2. A=0, B=1 -> D=0xFFFFFFFF, bout=1, ovf=0.
//      A=0x80000000, B=1 -> D=0x7FFFFFFF, bout=0, ovf=1.
//   3. Back-to-back, one per cycle: (0xF6B9EC29, 0xF0FFF00F), (5, 3, bin=1), (0, 0, bin=1)
//      -> consecutive outputs 0x05B9FC1A/bout0, 0x00000001/bout0, 0xFFFFFFFF/bout1.
//   4. Stall: drop en for 3 cycles with 3 operations in flight
//      -> outputs and out_valid frozen; results resume in order and none are lost or duplicated.
//   5. Assert rst for 1 cycle while 4 operations are in flight
//      -> out_valid=0 and D=0 next cycle; no stale result appears over the following 7 cycles.
//   6. Random: 10k vectors with random en and in_valid, checked against the reference model
//      D = A - B - bin, bout, ovf; also run at WIDTH=8, LOG_W=3.

Source files
------------

// File: rtl/rd_pipelined_subtractor.sv
// Pipelined WIDTH-bit subtractor D = A - B - bin. Borrows are resolved by a
// Kogge-Stone style kill/propagate/generate prefix over A + ~B + ~bin.
module rd_pipelined_subtractor #(
    parameter int WIDTH = 32,
    parameter int LOG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             ovf,
    output logic             out_valid
);

    // Position j of a KPG vector describes bit j-1; position 0 is the borrow-in.
    // Encoding: K = (g0,p0), G = (g1,p0), P = (g0,p1).
    logic [LOG_W:0][WIDTH:0]   g_q, p_q;
    logic [LOG_W:1][WIDTH:0]   g_n, p_n;
    logic [LOG_W:0][WIDTH-1:0] h_q;
    logic [LOG_W:0]            v_q, am_q, bm_q;

    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   g_in, p_in;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] d_n;

    always_comb begin
        y    = ~B;
        g_in = {A & y, ~bin};
        p_in = {A ^ y, 1'b0};
    end

    always_comb begin
        g_n = '0;
        p_n = '0;
        for (int k = 1; k <= LOG_W; k++) begin
            for (int j = 0; j <= WIDTH; j++) begin
                if (j >= (1 << (k - 1))) begin
                    g_n[k][j] = g_q[k-1][j] | (p_q[k-1][j] & g_q[k-1][j - (1 << (k - 1))]);
                    p_n[k][j] = p_q[k-1][j] & p_q[k-1][j - (1 << (k - 1))];
                end else begin
                    g_n[k][j] = g_q[k-1][j];
                    p_n[k][j] = p_q[k-1][j];
                end
            end
        end
    end

    // The doubling span reaches WIDTH positions, so only the top position can
    // still be P; folding the borrow-in position into every slot finishes it.
    always_comb begin
        carry = g_q[LOG_W] | (p_q[LOG_W] & {(WIDTH + 1){g_q[LOG_W][0]}});
        d_n   = h_q[LOG_W] ^ carry[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q       <= '0;
            p_q       <= '0;
            h_q       <= '0;
            v_q       <= '0;
            am_q      <= '0;
            bm_q      <= '0;
            D         <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            g_q[0]  <= g_in;
            p_q[0]  <= p_in;
            h_q[0]  <= A ^ y;
            v_q[0]  <= in_valid;
            am_q[0] <= A[WIDTH-1];
            bm_q[0] <= B[WIDTH-1];
            for (int k = 1; k <= LOG_W; k++) begin
                g_q[k]  <= g_n[k];
                p_q[k]  <= p_n[k];
                h_q[k]  <= h_q[k-1];
                v_q[k]  <= v_q[k-1];
                am_q[k] <= am_q[k-1];
                bm_q[k] <= bm_q[k-1];
            end
            D         <= d_n;
            bout      <= ~carry[WIDTH];
            ovf       <= (am_q[LOG_W] != bm_q[LOG_W]) && (d_n[WIDTH-1] != am_q[LOG_W]);
            out_valid <= v_q[LOG_W];
        end
    end

endmodule
